// File: rtl/game_tick_gen.sv
// Game clock/tick generator: power-of-two rate select, pause, single-step.
// Optional macro TICK_GEN_IMM_RATE_EN: restart immediately on a rate change.
module game_tick_gen #(
    parameter int BASE_CNT = 12_500_000,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] clk_rate,
    input  logic             pause,
    input  logic             step,
    output logic             clk_game,
    output logic             game_tick,
    output logic [SEL_W-1:0] rate_act,
    output logic             paused
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        STEP   = 2'd2
    } state_t;

    localparam int MAX_SH = (1 << SEL_W) - 1;
    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_CNT);
    localparam logic [CNT_W-1:0] TOP  = BASE << MAX_SH;
    localparam bit FITS = ((TOP >> MAX_SH) == BASE) && (BASE != '0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic             term;
    logic             rate_diff;

    assign half = BASE << rate_act;
    assign term = (cnt == half - CNT_W'(1));

`ifdef TICK_GEN_IMM_RATE_EN
    assign rate_diff = (clk_rate != rate_act);
`else
    assign rate_diff = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_game  <= 1'b0;
            game_tick <= 1'b0;
            rate_act  <= clk_rate;
            state     <= RUN;
            paused    <= 1'b0;
        end else begin
            if (state != PAUSED) begin
                if (term) begin
                    cnt       <= '0;
                    clk_game  <= ~clk_game;
                    rate_act  <= clk_rate;
                    game_tick <= ~clk_game;
                end else if (rate_diff) begin
                    cnt       <= '0;
                    rate_act  <= clk_rate;
                    game_tick <= 1'b0;
                end else begin
                    cnt       <= cnt + CNT_W'(1);
                    game_tick <= 1'b0;
                end
            end else begin
                game_tick <= 1'b0;
                // a rate change while frozen arms a restart for exit
                if (rate_diff) begin
                    cnt      <= '0;
                    rate_act <= clk_rate;
                end
            end

            unique case (state)
                RUN: begin
                    if (pause) begin
                        state  <= PAUSED;
                        paused <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause) begin
                        state  <= RUN;
                        paused <= 1'b0;
                    end else if (step) begin
                        state  <= STEP;
                        paused <= 1'b0;
                    end
                end
                STEP: begin
                    if (term && !clk_game) begin
                        state  <= pause ? PAUSED : RUN;
                        paused <= pause;
                    end
                end
                default: begin
                    state  <= RUN;
                    paused <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        assert (FITS)
        else $error("game_tick_gen: BASE_CNT << max rate overflows CNT_W");
    end

endmodule
